bitonic_sort_sched_16: RTL and testbench
========================================

# bitonic_sort_sched_16

Sequential scheduler for 16-line temporal sorting. Opens one gamma window, timestamps the first 1->0 transition on each input line, then steps a single shared compare-exchange unit through the 10 stages of a 16-input bitonic network. The result is the arrival-time-ordered list of times and line indices. It sits between raw spike lines and downstream WTA/column logic, and replaces the fully-unrolled combinational sorter where area matters.

## Interface
- T_W, 4: timestamp width; code 2^T_W-1 = INF (no spike)
- GAMMA, 12: capture window length in cycles; must be ≤ 2^T_W-1
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a capture+sort; accepted only in IDLE
- raw_in  in  16  spike lines, idle high, event = 1->0 transition
- busy  out  1  high in CAPTURE and SORT
- out_valid  out  1  sorted result available (HOLD)
- out_ready  in  1  consumer accepts result
- sorted_time  out  16*T_W  slot s at [s*T_W +: T_W], ascending
- sorted_idx  out  64  slot s at [s*4 +: 4], original line of slot s

## Operation
- States: IDLE -> CAPTURE -> SORT -> HOLD -> IDLE.
- IDLE:
  - start=1 at an edge: register raw_in as prev, load all times with INF and idx[i]=i, clear tick counter t, go to CAPTURE.
- CAPTURE (GAMMA cycles, t=0..GAMMA-1):
  - A line with prev=1 and raw_in=0 whose time is still INF records t.
  - Later edges on the same line are ignored (first event wins).
  - A line low at start, with no 1->0 edge, stays INF.
  - After t=GAMMA-1, go to SORT.
- SORT:
  - Stage counter covers (k,j) pairs: k=2,4,8,16; j=k/2 down to 1.
  - Pair counter p=0..7. Address i = p with a 0 inserted at bit log2(j); partner l = i|j.
  - Direction is ascending if (i&k)==0, else descending.
  - One compare-exchange per cycle; the read-modify-write of entries i and l completes in that cycle.
  - Key order: (time, idx) lexicographic. Ties resolve by lower index first, so the result is fully deterministic.
  - After 80 cycles, go to HOLD.
- HOLD:
  - out_valid=1; sorted_time and sorted_idx held stable.
  - On out_valid & out_ready, go to IDLE.
- start while busy or in HOLD is ignored (not queued).
- rst at any time clears state to IDLE and the register file to 0; an in-flight sort is discarded.

## Timing
- Reset values: busy=0, out_valid=0, sorted_time=0, sorted_idx=0.
- Start accepted at edge E0. busy rises after E0. raw_in is sampled at edges E1..E_GAMMA with t=0..GAMMA-1.
- SORT occupies edges E_GAMMA+1..E_GAMMA+80. out_valid and final data appear after edge E_GAMMA+80. busy falls in the same cycle.
- Handshake completes on the edge where out_valid & out_ready. out_valid drops after that edge. A new start is accepted no earlier than the following edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- BITONIC_SCHED_DUAL_CX_EN defined:
  - Two compare-exchange units per cycle (pairs 2p and 2p+1).
  - SORT lasts 40 cycles; out_valid after edge E_GAMMA+40.
- Undefined: single unit, 80 cycles.
- Results are identical in both builds.

## Structure
- Package tnn_sort_pkg holds:
  - N=16, LOG_N=4, N_STAGES=10, PAIRS=8
  - state enum {IDLE, CAPTURE, SORT, HOLD}
  - function pair_addr(p, j)
- Sub-module bitonic_cx: combinational compare-exchange of two (time, idx) entries with a direction input. Instantiated once, or twice under the macro.

## Test plan
- Lines 0..11 fall at t=11-i, lines 12..15 silent -> sorted_time=0..11,15,15,15,15; sorted_idx=11,10,...,0,12,13,14,15.
- All lines silent for the whole window -> all times 15; idx 0..15 in order.
- All 16 lines fall at t=3 -> all times 3; idx 0..15 (tie rule).
- Line 5 low before start and stays low; line 9 falls at t=2, rises, falls at t=6 -> line5=INF, line9=2.
- out_ready held 0 for 20 cycles in HOLD, start pulsed meanwhile -> out_valid and data stable, start ignored; release -> IDLE next edge.
- rst asserted mid-SORT (cycle 40) -> busy=0, out_valid=0, outputs 0 immediately; next start gives correct result with nominal latency. Repeat the latency check with BITONIC_SCHED_DUAL_CX_EN set.

Source files
------------

// File: rtl/tnn_sort_pkg.sv
// Shared sizing, FSM state type and bitonic pair addressing for the 16-line temporal sorter.
// Pure declarations: no latency, no backpressure.
package tnn_sort_pkg;
    localparam int N        = 16;
    localparam int LOG_N    = 4;
    localparam int N_STAGES = 10;
    localparam int PAIRS    = 8;

    typedef enum logic [1:0] {IDLE, CAPTURE, SORT, HOLD} state_t;

    // Lower entry of pair p in a stage of partner distance 2^jlog: p with a 0 inserted at bit jlog.
    function automatic logic [LOG_N-1:0] pair_addr(input logic [LOG_N-2:0] p, input logic [1:0] jlog);
        logic [LOG_N-1:0] pe;
        logic [LOG_N-1:0] lo_mask;
        pe      = {1'b0, p};
        lo_mask = (4'd1 << jlog) - 4'd1;
        return ((pe & ~lo_mask) << 1) | (pe & lo_mask);
    endfunction
endpackage

// File: rtl/bitonic_cx.sv
// Combinational compare-exchange of two (time, idx) keys; x gets the smaller key unless desc.
// Zero latency, no backpressure.
module bitonic_cx
    import tnn_sort_pkg::*;
#(
    parameter int T_W = 4
) (
    input  logic [T_W-1:0]   a_time,
    input  logic [LOG_N-1:0] a_idx,
    input  logic [T_W-1:0]   b_time,
    input  logic [LOG_N-1:0] b_idx,
    input  logic             desc,
    output logic [T_W-1:0]   x_time,
    output logic [LOG_N-1:0] x_idx,
    output logic [T_W-1:0]   y_time,
    output logic [LOG_N-1:0] y_idx
);
    logic a_gt_b;
    logic swap;

    always_comb begin
        // Index breaks time ties, so keys are always distinct and the order is total.
        a_gt_b = (a_time > b_time) || ((a_time == b_time) && (a_idx > b_idx));
        swap   = desc ? !a_gt_b : a_gt_b;
        x_time = swap ? b_time : a_time;
        x_idx  = swap ? b_idx  : a_idx;
        y_time = swap ? a_time : b_time;
        y_idx  = swap ? a_idx  : b_idx;
    end
endmodule

// File: rtl/bitonic_sort_sched_16.sv
// Captures first 1->0 edge time per line over GAMMA cycles, then bitonic-sorts (time, idx) with shared CX units.
// Result after GAMMA+80 edges (GAMMA+40 with BITONIC_SCHED_DUAL_CX_EN); held in HOLD until out_ready, start ignored while not IDLE.
module bitonic_sort_sched_16
    import tnn_sort_pkg::*;
#(
    parameter int T_W   = 4,
    parameter int GAMMA = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N-1:0]       raw_in,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*T_W-1:0]   sorted_time,
    output logic [N*LOG_N-1:0] sorted_idx
);
`ifdef BITONIC_SCHED_DUAL_CX_EN
    localparam int CX_N = 2;
`else
    localparam int CX_N = 1;
`endif
    localparam int             P_W    = LOG_N - 1;
    localparam logic [T_W-1:0] INF    = '1;
    localparam logic [T_W-1:0] T_LAST = T_W'(GAMMA - 1);
    localparam logic [P_W-1:0] P_LAST = P_W'(PAIRS - CX_N);

    state_t             state_q, state_d;
    logic               busy_d, valid_d;
    logic [T_W-1:0]     time_q [N];
    logic [LOG_N-1:0]   idx_q  [N];
    logic [N-1:0]       prev_q;
    logic [T_W-1:0]     t_q;
    logic [2:0]         klog_q;
    logic [1:0]         jlog_q;
    logic [P_W-1:0]     p_q;
    logic               cap_done, pass_end, sort_done;

    logic [LOG_N-1:0]   ai [CX_N];
    logic [LOG_N-1:0]   al [CX_N];
    logic               desc [CX_N];
    logic [T_W-1:0]     x_time [CX_N];
    logic [T_W-1:0]     y_time [CX_N];
    logic [LOG_N-1:0]   x_idx  [CX_N];
    logic [LOG_N-1:0]   y_idx  [CX_N];

    assign cap_done  = (t_q == T_LAST);
    assign pass_end  = (p_q == P_LAST);
    assign sort_done = pass_end && (klog_q == 3'(LOG_N)) && (jlog_q == 2'd0);

    for (genvar u = 0; u < CX_N; u++) begin : g_cx
        assign ai[u]   = pair_addr(p_q + P_W'(u), jlog_q);
        assign al[u]   = ai[u] | (4'd1 << jlog_q);
        // Final merge (k = N) is always ascending.
        assign desc[u] = (klog_q < 3'(LOG_N)) ? ai[u][klog_q[1:0]] : 1'b0;

        bitonic_cx #(.T_W(T_W)) u_cx (
            .a_time (time_q[ai[u]]),
            .a_idx  (idx_q[ai[u]]),
            .b_time (time_q[al[u]]),
            .b_idx  (idx_q[al[u]]),
            .desc   (desc[u]),
            .x_time (x_time[u]),
            .x_idx  (x_idx[u]),
            .y_time (y_time[u]),
            .y_idx  (y_idx[u])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy      <= busy_d;
            out_valid <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)                  state_d = CAPTURE;
            CAPTURE: if (cap_done)               state_d = SORT;
            SORT:    if (sort_done)              state_d = HOLD;
            HOLD:    if (out_valid && out_ready) state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d  = (state_d == CAPTURE) || (state_d == SORT);
        valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                time_q[i] <= '0;
                idx_q[i]  <= '0;
            end
            prev_q <= '0;
            t_q    <= '0;
            klog_q <= 3'd1;
            jlog_q <= 2'd0;
            p_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    prev_q <= raw_in;
                    t_q    <= '0;
                    for (int i = 0; i < N; i++) begin
                        time_q[i] <= INF;
                        idx_q[i]  <= LOG_N'(i);
                    end
                end
                CAPTURE: begin
                    prev_q <= raw_in;
                    t_q    <= t_q + T_W'(1);
                    for (int i = 0; i < N; i++)
                        if (prev_q[i] && !raw_in[i] && (time_q[i] == INF))
                            time_q[i] <= t_q;
                    if (cap_done) begin
                        klog_q <= 3'd1;
                        jlog_q <= 2'd0;
                        p_q    <= '0;
                    end
                end
                SORT: begin
                    // Pairs within one stage are disjoint, so parallel units never collide.
                    for (int u = 0; u < CX_N; u++) begin
                        time_q[ai[u]] <= x_time[u];
                        idx_q[ai[u]]  <= x_idx[u];
                        time_q[al[u]] <= y_time[u];
                        idx_q[al[u]]  <= y_idx[u];
                    end
                    p_q <= pass_end ? '0 : p_q + P_W'(CX_N);
                    if (pass_end) begin
                        if (jlog_q == 2'd0) begin
                            klog_q <= klog_q + 3'd1;
                            jlog_q <= klog_q[1:0];
                        end else begin
                            jlog_q <= jlog_q - 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar s = 0; s < N; s++) begin : g_out
        assign sorted_time[s*T_W +: T_W]     = time_q[s];
        assign sorted_idx[s*LOG_N +: LOG_N]  = idx_q[s];
    end
endmodule

// File: tb/tb_bitonic_sort_sched_16.sv
// Scoreboard bench for bitonic_sort_sched_16: directed capture patterns, hold/backpressure and reset-abort cases.
module tb_bitonic_sort_sched_16;
    localparam int T_W   = 4;
    localparam int GAMMA = 12;
`ifdef BITONIC_SCHED_DUAL_CX_EN
    localparam int SORT_CYC = 40;
`else
    localparam int SORT_CYC = 80;
`endif

    typedef struct packed {
        logic [16*T_W-1:0] t;
        logic [63:0]       i;
    } res_t;

    logic              clk, rst, start, busy, out_valid, out_ready;
    logic [15:0]       raw_in;
    logic [16*T_W-1:0] sorted_time;
    logic [63:0]       sorted_idx;

    res_t              sb[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    logic [15:0]       pat [0:GAMMA];
    logic [T_W-1:0]    exp_t [16];
    logic [3:0]        exp_i [16];

    bitonic_sort_sched_16 #(.T_W(T_W), .GAMMA(GAMMA)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .raw_in      (raw_in),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sorted_time (sorted_time),
        .sorted_idx  (sorted_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic res_t pack_exp();
        res_t r;
        for (int s = 0; s < 16; s++) begin
            r.t[s*T_W +: T_W] = exp_t[s];
            r.i[s*4 +: 4]     = exp_i[s];
        end
        return r;
    endfunction

    // Monitor: compares each accepted result with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 64'd1, {63'd0, out_valid} - 64'd1);
            end else begin
                res_t e;
                e = sb.pop_front();
                chk("sorted_time", sorted_time, e.t);
                chk("sorted_idx", sorted_idx, e.i);
            end
        end
    end

    // Pattern builders: pat[0] is raw_in at the accepting edge, pat[t+1] is raw_in for tick t.
    task automatic build_ramp();
        for (int w = 0; w <= GAMMA; w++)
            for (int i = 0; i < 16; i++)
                pat[w][i] = !((i < 12) && (w >= 1) && (w - 1 >= 11 - i));
        for (int s = 0; s < 16; s++) begin
            exp_t[s] = (s < 12) ? T_W'(s) : 4'd15;
            exp_i[s] = (s < 12) ? 4'(11 - s) : 4'(s);
        end
    endtask

    task automatic build_silent();
        for (int w = 0; w <= GAMMA; w++) pat[w] = 16'hFFFF;
        for (int s = 0; s < 16; s++) begin
            exp_t[s] = 4'd15;
            exp_i[s] = 4'(s);
        end
    endtask

    task automatic build_tie();
        for (int w = 0; w <= GAMMA; w++) pat[w] = (w >= 1 && w - 1 >= 3) ? 16'h0000 : 16'hFFFF;
        for (int s = 0; s < 16; s++) begin
            exp_t[s] = 4'd3;
            exp_i[s] = 4'(s);
        end
    endtask

    task automatic build_glitch();
        for (int w = 0; w <= GAMMA; w++) begin
            int tk;
            tk = w - 1;
            pat[w]    = 16'hFFFF;
            pat[w][5] = 1'b0;
            pat[w][9] = !((w >= 1) && ((tk == 2) || (tk == 3) || (tk >= 6)));
        end
        for (int s = 0; s < 16; s++) begin
            exp_t[s] = (s == 0) ? 4'd2 : 4'd15;
            exp_i[s] = (s == 0) ? 4'd9 : (s <= 9) ? 4'(s - 1) : 4'(s);
        end
    endtask

    // Issues one capture+sort; returns once out_valid is seen, or after reset when abort_at != 0.
    task automatic run(input int abort_at);
        int   n;
        logic got;
        @(posedge clk); #1;
        raw_in = pat[0];
        start  = 1'b1;
        if (abort_at == 0) sb.push_back(pack_exp());
        @(posedge clk); #1;
        start  = 1'b0;
        raw_in = pat[1];
        chk("busy_rise", {63'd0, busy}, 64'd1);
        for (int t = 1; t < GAMMA; t++) begin
            @(posedge clk); #1;
            raw_in = pat[t+1];
        end
        n   = GAMMA - 1;
        got = 1'b0;
        while (n < GAMMA + SORT_CYC + 50) begin
            @(posedge clk); #1;
            n++;
            if (abort_at != 0 && n == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_busy", {63'd0, busy}, 64'd0);
                chk("abort_valid", {63'd0, out_valid}, 64'd0);
                chk("abort_time", sorted_time, 64'd0);
                chk("abort_idx", sorted_idx, 64'd0);
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("valid_seen", {63'd0, got}, 64'd1);
        chk("latency", 64'(n), 64'(GAMMA + SORT_CYC));
        chk("busy_fall", {63'd0, busy}, 64'd0);
    endtask

    task automatic handshake();
        @(posedge clk); #1;
        chk("valid_drop", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        res_t e;
        rst       = 1'b1;
        start     = 1'b0;
        raw_in    = 16'hFFFF;
        out_ready = 1'b1;
        #2;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_time", sorted_time, 64'd0);
        chk("rst_idx", sorted_idx, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        build_ramp();   run(0); handshake();
        build_silent(); run(0); handshake();
        build_tie();    run(0); handshake();
        build_glitch(); run(0); handshake();

        // Backpressure in HOLD with an ignored start pulse.
        out_ready = 1'b0;
        build_ramp();
        e = pack_exp();
        run(0);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            start = (c == 5);
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_busy", {63'd0, busy}, 64'd0);
            chk("hold_time", sorted_time, e.t);
            chk("hold_idx", sorted_idx, e.i);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        handshake();
        chk("post_hold_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        chk("no_queued_start", {63'd0, busy}, 64'd0);

        // Reset mid-SORT, then a clean run with nominal latency.
        build_tie();    run(GAMMA + SORT_CYC / 2);
        build_glitch(); run(0); handshake();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule
